// File: rtl/memory_pairs_checker.sv
// Player-input side of the memory game: latches the six expected digits on start
// and scores the player's guesses against them in order, with an optional inactivity timeout.
module memory_pairs_checker #(
    parameter int NUM_DIGITS     = 6,
    parameter int DIGIT_W        = 4,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DIGIT_W-1:0] A,
    input  logic [DIGIT_W-1:0] B,
    input  logic [DIGIT_W-1:0] C,
    input  logic [DIGIT_W-1:0] D,
    input  logic [DIGIT_W-1:0] E,
    input  logic [DIGIT_W-1:0] F,
    input  logic [DIGIT_W-1:0] guess,
    input  logic               guess_load,
    output logic               busy,
    output logic [2:0]         index,
    output logic [2:0]         score,
    output logic               correct,
    output logic               wrong,
    output logic               win,
    output logic               lose,
    output logic               timed_out
);

    // A zero-cycle timeout still needs a 1-bit counter so the declarations stay legal.
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, GUESS, WIN, LOSE} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         index_reg, index_next;
    logic [2:0]         score_reg, score_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               correct_reg, correct_next;
    logic               wrong_reg, wrong_next;
    logic               timed_out_reg, timed_out_next;

    logic [DIGIT_W-1:0] in_digits [NUM_DIGITS];
    logic [DIGIT_W-1:0] digit_reg [NUM_DIGITS];
    logic               latch_en;

    assign in_digits[0] = A;
    assign in_digits[1] = B;
    assign in_digits[2] = C;
    assign in_digits[3] = D;
    assign in_digits[4] = E;
    assign in_digits[5] = F;

    // start only re-arms the round outside GUESS, so the digits are frozen during play.
    assign latch_en = start && (state_reg != GUESS);

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    digit_reg[gi] <= '0;
                end else if (latch_en) begin
                    digit_reg[gi] <= in_digits[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            index_reg     <= '0;
            score_reg     <= '0;
            cnt_reg       <= '0;
            correct_reg   <= 1'b0;
            wrong_reg     <= 1'b0;
            timed_out_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            index_reg     <= index_next;
            score_reg     <= score_next;
            cnt_reg       <= cnt_next;
            correct_reg   <= correct_next;
            wrong_reg     <= wrong_next;
            timed_out_reg <= timed_out_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        index_next     = index_reg;
        score_next     = score_reg;
        cnt_next       = cnt_reg;
        correct_next   = 1'b0;
        wrong_next     = 1'b0;
        timed_out_next = timed_out_reg;

        case (state_reg)
            GUESS: begin
                if (guess_load) begin
                    if (guess == digit_reg[index_reg]) begin
                        correct_next = 1'b1;
                        score_next   = score_reg + 3'd1;
                        cnt_next     = '0;
                        if (index_reg == LAST_IDX) begin
                            state_next = WIN;
                        end else begin
                            index_next = index_reg + 3'd1;
                        end
                    end else begin
                        wrong_next = 1'b1;
                        state_next = LOSE;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (cnt_reg == CNT_LAST) begin
                        wrong_next     = 1'b1;
                        timed_out_next = 1'b1;
                        state_next     = LOSE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_next     = GUESS;
                    index_next     = '0;
                    score_next     = '0;
                    cnt_next       = '0;
                    timed_out_next = 1'b0;
                end
            end
        endcase
    end

    assign busy      = (state_reg == GUESS);
    assign win       = (state_reg == WIN);
    assign lose      = (state_reg == LOSE);
    assign index     = index_reg;
    assign score     = score_reg;
    assign correct   = correct_reg;
    assign wrong     = wrong_reg;
    assign timed_out = timed_out_reg;

endmodule

// File: tb/tb_memory_pairs_checker.sv
// Bench for memory_pairs_checker: directed rounds checked against a cycle-counting
// behavioural model every cycle, plus hand-computed literal expectations.
module tb_memory_pairs_checker;

    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] A = 4'd0, B = 4'd0, C = 4'd0, D = 4'd0, E = 4'd0, F = 4'd0;
    logic [3:0] guess = 4'd0;
    logic       guess_load = 1'b0;
    logic       busy, correct, wrong, win, lose, timed_out;
    logic [2:0] index, score;

    int tests = 0;
    int fails = 0;

    memory_pairs_checker #(
        .NUM_DIGITS(6), .DIGIT_W(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F),
        .guess(guess), .guess_load(guess_load),
        .busy(busy), .index(index), .score(score),
        .correct(correct), .wrong(wrong), .win(win), .lose(lose),
        .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    // Model: round phase plus the cycle stamp of the last counter clear;
    // a timeout fires when TO edges pass with no guess since that stamp.
    localparam int P_IDLE = 0, P_PLAY = 1, P_WON = 2, P_LOST = 3;
    int         cyc = 0;
    int         m_phase, m_pos, m_score, m_clear;
    logic [3:0] m_exp [6];
    logic       m_cor, m_wr, m_to;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= P_IDLE; m_pos <= 0; m_score <= 0; m_clear <= 0;
            m_cor <= 1'b0; m_wr <= 1'b0; m_to <= 1'b0;
            m_exp <= '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        end else begin
            m_cor <= 1'b0;
            m_wr  <= 1'b0;
            if (m_phase != P_PLAY) begin
                if (start) begin
                    m_phase <= P_PLAY; m_exp <= '{A, B, C, D, E, F};
                    m_pos <= 0; m_score <= 0; m_to <= 1'b0; m_clear <= cyc;
                end
            end else if (guess_load) begin
                if (guess == m_exp[m_pos]) begin
                    m_cor <= 1'b1; m_score <= m_score + 1; m_clear <= cyc;
                    if (m_pos == 5) m_phase <= P_WON;
                    else m_pos <= m_pos + 1;
                end else begin
                    m_wr <= 1'b1; m_phase <= P_LOST;
                end
            end else if (cyc - m_clear == TO) begin
                m_wr <= 1'b1; m_to <= 1'b1; m_phase <= P_LOST;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy",      32'(busy),      32'(m_phase == P_PLAY));
        chk("win",       32'(win),       32'(m_phase == P_WON));
        chk("lose",      32'(lose),      32'(m_phase == P_LOST));
        chk("index",     32'(index),     32'(m_pos));
        chk("score",     32'(score),     32'(m_score));
        chk("correct",   32'(correct),   32'(m_cor));
        chk("wrong",     32'(wrong),     32'(m_wr));
        chk("timed_out", 32'(timed_out), 32'(m_to));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
        $display("[TB] start digits %0d %0d %0d %0d %0d %0d busy=%0d", A, B, C, D, E, F, busy);
    endtask

    task automatic do_guess(input logic [3:0] g);
        guess = g; guess_load = 1'b1; tick(); guess_load = 1'b0;
        $display("[TB] guess %0d -> correct=%0d wrong=%0d index=%0d score=%0d win=%0d lose=%0d",
                 g, correct, wrong, index, score, win, lose);
    endtask

    initial begin
        int n;
        idle(2);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_outs", 32'({index, score, correct, wrong, win, lose, timed_out}), 0);
        rst = 1'b1;
        idle(2);

        // Full win
        {A, B, C, D, E, F} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        do_start();
        for (int i = 1; i <= 6; i++) begin
            do_guess(4'(i));
            chk("win_correct", 32'(correct), 1);
            chk("win_score", 32'(score), 32'(i));
            idle(3);
        end
        chk("win_level", 32'(win), 1);
        chk("win_busy", 32'(busy), 0);
        chk("win_index", 32'(index), 5);

        // Mismatch at position 3
        do_start();
        do_guess(4'd1); idle(3);
        do_guess(4'd2); idle(3);
        do_guess(4'd9);
        chk("mm_wrong", 32'(wrong), 1);
        chk("mm_lose", 32'(lose), 1);
        chk("mm_score", 32'(score), 2);
        chk("mm_index", 32'(index), 2);
        chk("mm_timed_out", 32'(timed_out), 0);
        do_guess(4'd3);
        chk("mm_ignored", 32'({correct, wrong}), 0);
        idle(2);

        // Timeout after one correct guess
        do_start();
        do_guess(4'd1);
        n = 0;
        while (!lose && n < 2 * TO) begin
            tick();
            n++;
        end
        $display("[TB] timeout after %0d idle cycles lose=%0d timed_out=%0d", n, lose, timed_out);
        chk("to_cycles", 32'(n), 32'(TO));
        chk("to_timed_out", 32'(timed_out), 1);
        chk("to_score", 32'(score), 1);
        idle(2);

        // Latch isolation and restart
        {A, B, C, D, E, F} = {4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7};
        do_start();
        A = 4'd0;
        do_guess(4'd7);
        chk("latch_correct", 32'(correct), 1);
        do_guess(4'd3);
        chk("latch_lose", 32'(lose), 1);
        do_start();
        chk("restart_clear", 32'({win, lose, timed_out, score, index}), 0);
        chk("restart_busy", 32'(busy), 1);
        do_guess(4'd0);
        chk("restart_correct", 32'(correct), 1);

        // start coinciding with a guess in GUESS is ignored
        A = 4'd5;
        start = 1'b1;
        do_guess(4'd7);
        start = 1'b0;
        chk("sim_correct", 32'(correct), 1);
        chk("sim_index", 32'(index), 2);
        chk("sim_score", 32'(score), 2);
        idle(1);

        // Asynchronous reset mid-round, away from a clock edge
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("arst_outs", 32'({busy, score, index, win, lose}), 0);
        $display("[TB] async reset busy=%0d score=%0d index=%0d", busy, score, index);
        do_guess(4'd0);
        rst = 1'b1;
        do_guess(4'd0);
        chk("idle_guess", 32'({busy, correct, wrong, score, index}), 0);
        idle(3);
        chk("idle_no_start", 32'(busy), 0);
        do_start();
        chk("post_rst_start", 32'(busy), 1);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/memory_pairs_checker.md
Name: memory_pairs_checker

Overview:
- Player-input end of the memory game: consumes the six 4-bit digits A–F produced by the pair generator and checks the player's entered digits against them, in order.
- Sits between the button/switch input shaper and the game-control / display logic.
- Reports per-digit correct/wrong pulses, a running score, and a terminal win/lose result.

Parameters:
- NUM_DIGITS, 6, number of digits in one round (A..F); fixed at 6 for this revision.
- DIGIT_W, 4, width of each digit.
- TIMEOUT_CYCLES, 50000000, clock cycles allowed between accepted guesses; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a round and latches A–F
- A, B, C, D, E, F  in  4 each  expected digits from the pair generator, in entry order
- guess  in  4  player's digit
- guess_load  in  1  one-cycle pulse from the input shaper; guess is valid in this cycle
- busy  out  1  round in progress (state GUESS)
- index  out  3  position of the next digit expected, 0..5
- score  out  3  count of correct digits this round, 0..6
- correct  out  1  one-cycle pulse: the last guess matched
- wrong  out  1  one-cycle pulse: the last guess mismatched
- win  out  1  level: all six digits matched
- lose  out  1  level: mismatch or timeout
- timed_out  out  1  level: the loss was caused by timeout

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; latched digits 0; timeout counter 0.
- State IDLE:
  - start=1 at an edge → latch A–F into internal registers; index=0; score=0; counter=0; go to GUESS.
  - Later changes on A–F have no effect until the next start.
- State GUESS (busy=1):
  - guess_load=1 at an edge → compare guess with latched digit[index]. Result is registered, so the pulse is seen 1 cycle after the load edge.
  - Match with index<5 → correct=1 for one cycle; index+1; score+1; counter cleared; stay in GUESS.
  - Match with index=5 → correct=1; score=6; index stays at 5; go to WIN.
  - Mismatch → wrong=1 for one cycle; score unchanged; go to LOSE.
  - No guess_load → counter increments. When counter reaches TIMEOUT_CYCLES-1 → go to LOSE with timed_out=1 and wrong=1 pulse.
  - If TIMEOUT_CYCLES=0, the counter is held at 0 and no timeout occurs.
  - start is ignored in GUESS, including when it coincides with guess_load; the guess is processed normally.
- State WIN: win=1, busy=0. Holds until start.
- State LOSE: lose=1, busy=0. index and score freeze at their failure values. Holds until start.
- start in WIN or LOSE behaves exactly as start in IDLE: re-latch A–F, clear win, lose, timed_out, score and index, go to GUESS.
- guess_load outside GUESS is ignored: no pulses, no counter change.
- correct and wrong are never high in the same cycle. win and lose are mutually exclusive.
- Arithmetic: score is a 3-bit register that saturates at 6 by construction. The counter width is ceil(log2(TIMEOUT_CYCLES+1)).
- Reset mid-round: all outputs immediately 0; state returns to IDLE.

Test Plan:
- Full win: A..F=1,2,3,4,5,6; start; guesses 1,2,3,4,5,6, each one pulse with 3 idle cycles between → correct pulses ×6; score steps 1..6; win=1 the cycle after the 6th load; busy=0.
- Mismatch at position 3: same digits; guesses 1,2,9 → correct ×2; wrong pulse; lose=1; score=2; index=2; timed_out=0. Further guess_load pulses produce no response.
- Timeout: TIMEOUT_CYCLES=20; start; one correct guess, then idle → lose=1 and timed_out=1 exactly 20 cycles after the counter clears; score=1.
- Latch isolation and restart: start with A..F=7,7,7,7,7,7; change A to 0 mid-round; guess 7 → correct. Force lose; apply start with A=0 → win, lose and score cleared; guess 0 → correct.
- Simultaneous and ignored inputs: in GUESS, start and guess_load in the same cycle with a correct guess → correct=1, index advances, no restart. guess_load in IDLE → outputs stay 0.
- Async reset: assert rst=0 mid-round, off a clock edge → busy, score, index, win and lose all 0 immediately; after release, round starts only on start.
